// File: rtl/uart_pkg.sv
// Shared types and constants for the AES serial link UART (receiver and transmitter).
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_DONE  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB-first, 1 stop, no parity; samples every bit at mid-bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_serial_in,
    output logic [DATA_WIDTH-1:0] rx_byte_out,
    output logic                  rx_done,
    output logic                  rx_active,
    output logic                  rx_frame_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      clk_count_q, clk_count_d;
    logic [2:0]            bit_index_q, bit_index_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
    logic                  rx_done_q, rx_done_d;
    logic                  rx_active_q, rx_active_d;
    logic                  rx_frame_err_q, rx_frame_err_d;
    logic                  rx_s;
    logic                  half_end;
    logic                  bit_end;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_serial_in),
        .q     (rx_s)
    );

    assign half_end = (clk_count_q == HALF_BIT);
    assign bit_end  = (clk_count_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            clk_count_q    <= '0;
            bit_index_q    <= '0;
            shift_q        <= '0;
            rx_byte_q      <= '0;
            rx_done_q      <= 1'b0;
            rx_active_q    <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_count_q    <= clk_count_d;
            bit_index_q    <= bit_index_d;
            shift_q        <= shift_d;
            rx_byte_q      <= rx_byte_d;
            rx_done_q      <= rx_done_d;
            rx_active_q    <= rx_active_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        case (state_q)
            IDLE: begin
                clk_count_d = '0;
                bit_index_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (half_end) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    state_d     = rx_s ? IDLE : DATA;
                end else begin
                    clk_count_d = clk_count_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rx_s;
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = '0;
                        state_d     = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_count_d = '0;
                    state_d     = rx_s ? IDLE : WAIT_IDLE;
                end else begin
                    clk_count_d = clk_count_q + CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                // A held-low line must return high before another start bit is accepted.
                clk_count_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                clk_count_d = '0;
                bit_index_d = '0;
            end
        endcase
    end

    always_comb begin
        rx_byte_d      = rx_byte_q;
        rx_done_d      = 1'b0;
        rx_frame_err_d = 1'b0;
        rx_active_d    = (state_d == START) || (state_d == DATA) || (state_d == STOP);
        if ((state_q == STOP) && bit_end) begin
            if (rx_s) begin
                rx_byte_d = shift_q;
                rx_done_d = 1'b1;
            end else begin
                rx_frame_err_d = 1'b1;
            end
        end
    end

    assign rx_byte_out  = rx_byte_q;
    assign rx_done      = rx_done_q;
    assign rx_active    = rx_active_q;
    assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: three receivers (16, 15 and 434 clk/bit) driven by a serial line model.
module tb_uart_rx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ser   = 3'b111;
    logic [7:0] byte_o [3];
    logic [2:0] done;
    logic [2:0] act;
    logic [2:0] ferr;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) u_rx16 (
        .clk(clk), .reset(reset), .rx_serial_in(ser[0]), .rx_byte_out(byte_o[0]),
        .rx_done(done[0]), .rx_active(act[0]), .rx_frame_err(ferr[0]));
    uart_rx #(.CLKS_PER_BIT(15)) u_rx15 (
        .clk(clk), .reset(reset), .rx_serial_in(ser[1]), .rx_byte_out(byte_o[1]),
        .rx_done(done[1]), .rx_active(act[1]), .rx_frame_err(ferr[1]));
    uart_rx u_rx434 (
        .clk(clk), .reset(reset), .rx_serial_in(ser[2]), .rx_byte_out(byte_o[2]),
        .rx_done(done[2]), .rx_active(act[2]), .rx_frame_err(ferr[2]));

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] val;
    } ev_t;

    int  cyc = 0;
    ev_t log_q[$];
    int  ferr_cnt[3] = '{0, 0, 0};
    int  act_cnt[3]  = '{0, 0, 0};
    int  both_cnt    = 0;
    int  checks      = 0;
    int  errors      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) log_q.push_back('{i, cyc, byte_o[i]});
            if (ferr[i] === 1'b1) ferr_cnt[i]++;
            if (act[i] === 1'b1) act_cnt[i]++;
            if (done[i] === 1'b1 && ferr[i] === 1'b1) both_cnt++;
        end
    end

    // Behavioural serial transmitter; all line changes happen on falling edges.
    task automatic hold(input int sel, input logic v, input int n);
        ser[sel] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic stop_bit, input int cpb);
        hold(sel, 1'b0, cpb);
        for (int b = 0; b < 8; b++) hold(sel, d[b], cpb);
        hold(sel, stop_bit, cpb);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (byte_o[i] !== 8'h00 || done[i] !== 1'b0 || act[i] !== 1'b0 || ferr[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got byte=%h done=%b act=%b ferr=%b, expected all zero",
                         i, byte_o[i], done[i], act[i], ferr[i]);
            end
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (byte_o[i] !== 8'h00 || done[i] !== 1'b0 || act[i] !== 1'b0 || ferr[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: got byte=%h done=%b act=%b ferr=%b, expected all zero",
                         i, byte_o[i], done[i], act[i], ferr[i]);
            end
        end
    endtask

    task automatic test_single();
        int n0 = log_q.size();
        int f0 = ferr_cnt[0];
        int a0 = act_cnt[0];
        int exp_act = (16 - 1) / 2 + 1 + 9 * 16;
        send_frame(0, 8'hA5, 1'b1, 16);
        hold(0, 1'b1, 20);
        checks++;
        if (log_q.size() - n0 !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d done pulses, expected 1", log_q.size() - n0);
        end else begin
            checks++;
            if (log_q[n0].val !== 8'hA5 || log_q[n0].inst !== 0) begin
                errors++;
                $display("FAIL single_value: got %h (inst %0d), expected a5 (inst 0)", log_q[n0].val, log_q[n0].inst);
            end
        end
        checks++;
        if (ferr_cnt[0] - f0 !== 0) begin
            errors++;
            $display("FAIL single_ferr: got %0d frame errors, expected 0", ferr_cnt[0] - f0);
        end
        checks++;
        if (act_cnt[0] - a0 !== exp_act) begin
            errors++;
            $display("FAIL single_active: got %0d active cycles, expected %0d", act_cnt[0] - a0, exp_act);
        end
        checks++;
        if (byte_o[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: got %h, expected a5", byte_o[0]);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] prev = byte_o[0];
        int n0 = log_q.size();
        int f0 = ferr_cnt[0];
        int a0 = act_cnt[0];
        hold(0, 1'b0, 6);
        hold(0, 1'b1, 40);
        checks++;
        if (log_q.size() != n0 || ferr_cnt[0] != f0) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d done and %0d ferr, expected 0 and 0",
                     log_q.size() - n0, ferr_cnt[0] - f0);
        end
        checks++;
        if (act_cnt[0] - a0 > (16 - 1) / 2 + 1 || act[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_active: got %0d active cycles (act now %b), expected at most %0d and 0",
                     act_cnt[0] - a0, act[0], (16 - 1) / 2 + 1);
        end
        checks++;
        if (byte_o[0] !== prev) begin
            errors++;
            $display("FAIL glitch_byte: got %h, expected %h", byte_o[0], prev);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] prev = byte_o[0];
        logic [7:0] d    = 8'h3C;
        int n0 = log_q.size();
        int f0 = ferr_cnt[0];
        int a_mid;
        hold(0, 1'b0, 16);
        for (int b = 0; b < 8; b++) hold(0, d[b], 16);
        hold(0, 1'b0, 16);
        a_mid = act_cnt[0];
        hold(0, 1'b0, 40);
        checks++;
        if (ferr_cnt[0] - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d frame errors, expected 1", ferr_cnt[0] - f0);
        end
        checks++;
        if (act_cnt[0] - a_mid !== 0) begin
            errors++;
            $display("FAIL ferr_break_active: got %0d active cycles on held-low line, expected 0", act_cnt[0] - a_mid);
        end
        checks++;
        if (log_q.size() != n0 || byte_o[0] !== prev) begin
            errors++;
            $display("FAIL ferr_byte: got %0d done, byte %h; expected 0 done, byte %h", log_q.size() - n0, byte_o[0], prev);
        end
        hold(0, 1'b1, 16);
        send_frame(0, 8'h5A, 1'b1, 16);
        hold(0, 1'b1, 20);
        checks++;
        if (log_q.size() - n0 !== 1 || byte_o[0] !== 8'h5A) begin
            errors++;
            $display("FAIL ferr_recover: got %0d done, byte %h; expected 1 done, byte 5a", log_q.size() - n0, byte_o[0]);
        end
    endtask

    task automatic test_back_to_back(input int sel, input int cpb);
        logic [7:0] exp_q[$] = '{8'h00, 8'hFF, 8'h81};
        int n0;
        hold(sel, 1'b1, cpb);
        n0 = log_q.size();
        foreach (exp_q[k]) send_frame(sel, exp_q[k], 1'b1, cpb);
        hold(sel, 1'b1, 2 * cpb);
        checks++;
        if (log_q.size() - n0 !== 3) begin
            errors++;
            $display("FAIL b2b_count[%0d]: got %0d done pulses, expected 3", cpb, log_q.size() - n0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (log_q[n0 + k].val !== exp_q[k] || log_q[n0 + k].inst !== sel) begin
                    errors++;
                    $display("FAIL b2b_value[%0d] #%0d: got %h, expected %h", cpb, k, log_q[n0 + k].val, exp_q[k]);
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (log_q[n0 + k].cyc - log_q[n0 + k - 1].cyc !== 10 * cpb) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d] #%0d: got %0d cycles, expected %0d",
                             cpb, k, log_q[n0 + k].cyc - log_q[n0 + k - 1].cyc, 10 * cpb);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int f0;
        hold(0, 1'b1, 16);
        n0 = log_q.size();
        f0 = ferr_cnt[0];
        fork
            send_frame(0, 8'h96, 1'b1, 16);
            begin
                // Data bit 4 spans 80..96 cycles after the start edge; release lands in bit 7 (a 1).
                repeat (88) @(negedge clk);
                checks++;
                if (act[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_pre_active: got %b, expected 1", act[0]);
                end
                reset = 1'b1;
                #1;
                checks++;
                if (byte_o[0] !== 8'h00 || done[0] !== 1'b0 || act[0] !== 1'b0 || ferr[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_clear: got byte=%h done=%b act=%b ferr=%b, expected all zero",
                             byte_o[0], done[0], act[0], ferr[0]);
                end
                repeat (44) @(negedge clk);
                reset = 1'b0;
            end
        join
        hold(0, 1'b1, 40);
        checks++;
        if (log_q.size() != n0 || ferr_cnt[0] != f0) begin
            errors++;
            $display("FAIL midreset_partial: got %0d done and %0d ferr, expected 0 and 0",
                     log_q.size() - n0, ferr_cnt[0] - f0);
        end
        send_frame(0, 8'h69, 1'b1, 16);
        hold(0, 1'b1, 20);
        checks++;
        if (log_q.size() - n0 !== 1 || byte_o[0] !== 8'h69) begin
            errors++;
            $display("FAIL midreset_next: got %0d done, byte %h; expected 1 done, byte 69", log_q.size() - n0, byte_o[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int n0 = log_q.size();
        int f0 = ferr_cnt[0];
        int bad_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d   = 8'($urandom);
            logic       bad = ($urandom_range(0, 3) == 0);
            send_frame(0, d, !bad, 16);
            if (bad) begin
                bad_cnt++;
                hold(0, 1'b1, $urandom_range(16, 30));
            end else begin
                exp_q.push_back(d);
                hold(0, 1'b1, $urandom_range(0, 12));
            end
        end
        hold(0, 1'b1, 40);
        checks++;
        if (log_q.size() - n0 !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes, expected %0d", log_q.size() - n0, exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (log_q[n0 + k].val !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand_value #%0d: got %h, expected %h", k, log_q[n0 + k].val, exp_q[k]);
                end
            end
        end
        checks++;
        if (ferr_cnt[0] - f0 !== bad_cnt) begin
            errors++;
            $display("FAIL rand_ferr: got %0d frame errors, expected %0d", ferr_cnt[0] - f0, bad_cnt);
        end
    endtask

    task automatic test_default_baud();
        logic [7:0] d0 = 8'($urandom);
        logic [7:0] d1 = 8'($urandom);
        int n0;
        hold(2, 1'b1, 50);
        n0 = log_q.size();
        send_frame(2, 8'hC3, 1'b1, 434);
        hold(2, 1'b1, 100);
        checks++;
        if (log_q.size() - n0 !== 1 || byte_o[2] !== 8'hC3) begin
            errors++;
            $display("FAIL smoke434: got %0d done, byte %h; expected 1 done, byte c3", log_q.size() - n0, byte_o[2]);
        end
        // Transmitter about 1.8 percent fast, frames back to back.
        n0 = log_q.size();
        send_frame(2, d0, 1'b1, 426);
        send_frame(2, d1, 1'b1, 426);
        hold(2, 1'b1, 500);
        checks++;
        if (log_q.size() - n0 !== 2) begin
            errors++;
            $display("FAIL fast_tx_count: got %0d done pulses, expected 2", log_q.size() - n0);
        end else begin
            checks++;
            if (log_q[n0].val !== d0 || log_q[n0 + 1].val !== d1) begin
                errors++;
                $display("FAIL fast_tx_value: got %h %h, expected %h %h", log_q[n0].val, log_q[n0 + 1].val, d0, d1);
            end
            checks++;
            if (log_q[n0 + 1].cyc - log_q[n0].cyc !== 4260) begin
                errors++;
                $display("FAIL fast_tx_spacing: got %0d cycles, expected 4260", log_q[n0 + 1].cyc - log_q[n0].cyc);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back(0, 16);
        test_back_to_back(1, 15);
        test_reset_mid();
        test_random();
        test_default_baud();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL done_ferr_exclusive: got %0d overlapping cycles, expected 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
